// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
//
// UART receive front-end. The raw serial line is synchronised into the clk
// domain and sampled once per tick16 pulse (OVERSAMPLE ticks per bit). The
// start bit is confirmed at its centre. Each following bit is sampled one
// full bit period later, so every sample falls near the bit centre. Frames
// are 8N1 by default: one start bit, DATA_BITS data bits sent LSB first, and
// one stop bit.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   rx         raw serial line, idles high, asynchronous to clk
//   tick16     one-cycle enable at OVERSAMPLE x baud rate
//   rx_data    last correctly framed byte
//   rx_status  level; high while rx_data holds a byte not yet superseded.
//              It drops when the next start bit is detected.
//   frame_err  high when the most recent frame had a low stop bit
//   busy       high whenever a frame is in progress (state is not idle)

module uart_rx_oversample #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick16,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_status,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  // The start bit is checked half a bit in. Data and stop bits are then
  // checked one full bit period apart, so each sample lands mid-bit.
  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  // Two-flop synchroniser. Both flops reset to the idle line level.
  logic rx_meta_q;
  logic rx_s_q;

  state_e               state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 status_q, status_d;
  logic                 ferr_q, ferr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      status_q <= status_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    status_d = status_q;
    ferr_d   = ferr_q;

    // Without a tick, every register holds its value.
    if (tick16) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_d  = StStart;
            tick_d   = '0;
            // Dropping the status here keeps it low for most of a frame.
            // The consumer then always sees a clean rising edge.
            status_d = 1'b0;
          end
        end

        StStart: begin
          if (tick_q == TickHalf) begin
            tick_d = '0;
            if (!rx_s_q) begin
              state_d = StData;
              bit_d   = '0;
            end else begin
              // The line went high again before mid start bit, so this was a glitch.
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        StData: begin
          if (tick_q == TickLast) begin
            // Right shift: the first bit received (the LSB) ends up in bit 0.
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BitLast) begin
              state_d = StStop;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        StStop: begin
          if (tick_q == TickLast) begin
            tick_d = '0;
            if (rx_s_q) begin
              data_d   = shift_q;
              status_d = 1'b1;
              ferr_d   = 1'b0;
              state_d  = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        StBreak: begin
          // Wait for the line to go high. A line held low must not keep
          // triggering new start bits.
          if (rx_s_q) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_status = status_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed scenarios followed by random frames.
// Expected values come from a frame-level model: a frame whose stop bit is
// high delivers its byte, and a frame whose stop bit is low sets frame_err.
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       tick16;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       busy;

  int   n_vec = 0;
  int   n_err = 0;
  int   tick_div = 2;
  logic phase = 1'b0;
  int   cyc = 0;

  uart_rx_oversample #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .tick16   (tick16),
    .rx_data  (rx_data),
    .rx_status(rx_status),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) phase <= ~phase;
  always @(posedge clk) cyc <= cyc + 1;
  assign tick16 = (tick_div == 1) ? 1'b1 : phase;

  // Monitor: logs every rising edge of rx_status, plus the byte present at that moment.
  logic [7:0] got[$];
  int   rises = 0;
  int   falls = 0;
  int   rise_cyc = 0;
  logic busy_at_rise = 1'b1;
  logic prev_status = 1'b0;

  always @(negedge clk) begin
    if (rx_status && !prev_status) begin
      got.push_back(rx_data);
      rises        <= rises + 1;
      rise_cyc     <= cyc;
      busy_at_rise <= busy;
    end
    if (!rx_status && prev_status) falls <= falls + 1;
    prev_status <= rx_status;
  end

  // Model state
  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  logic       exp_err;
  logic       exp_stat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int n);
    send_bit(1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(d[i], n);
    send_bit(stop, n);
  endtask

  task automatic check_stream();
    check("n_bytes", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("byte%0d", i), got[i], exp_q[i]);
  endtask

  initial begin
    int         start_c;
    int         delta;
    int         r0;
    int         f0;
    int         nb;
    int         gap;
    logic [7:0] d;
    logic       stop;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_status", rx_status, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    align();
    reset = 1'b1;
    send_bit(1'b1, 64);

    // Single 0x55 frame at 16 ticks per bit
    start_c = cyc;
    send_frame(8'h55, 1'b1, 32);
    exp_q.push_back(8'h55);
    @(negedge clk);
    delta = rise_cyc - start_c;
    check("t1_data", rx_data, 8'h55);
    check("t1_status", rx_status, 1);
    check("t1_ferr", frame_err, 0);
    check("t1_busy", busy, 0);
    check("t1_rises", rises, 1);
    check("t1_busy_at_rise", busy_at_rise, 0);
    // A 9.5-bit delay at 32 clk per bit is 304 clk, plus sync and tick jitter.
    check("t1_rise_time", (delta >= 300 && delta <= 316), 1);

    // Two frames sent back-to-back
    align();
    f0 = falls;
    send_frame(8'hA3, 1'b1, 32);
    send_frame(8'h0F, 1'b1, 32);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    @(negedge clk);
    check("t2_data", rx_data, 8'h0F);
    check("t2_status", rx_status, 1);
    check("t2_falls", falls - f0, 2);
    check("t2_rises", rises, 3);
    check_stream();

    // A 4-tick low glitch while idle. Detecting it as a start bit clears rx_status.
    align();
    send_bit(1'b0, 8);
    send_bit(1'b1, 2);
    @(negedge clk);
    check("t3_busy_start", busy, 1);
    align();
    send_bit(1'b1, 40);
    @(negedge clk);
    check("t3_busy", busy, 0);
    check("t3_status", rx_status, 0);
    check("t3_data", rx_data, 8'h0F);
    check("t3_ferr", frame_err, 0);
    check("t3_rises", rises, 3);

    // Low stop bit, line held low (break), then a good frame
    align();
    send_frame(8'h3C, 1'b0, 32);
    send_bit(1'b0, 96);
    @(negedge clk);
    check("t4_ferr", frame_err, 1);
    check("t4_busy_break", busy, 1);
    check("t4_status", rx_status, 0);
    check("t4_data", rx_data, 8'h0F);
    check("t4_rises", rises, 3);
    align();
    send_bit(1'b1, 64);
    @(negedge clk);
    check("t4_busy_idle", busy, 0);
    align();
    send_frame(8'h81, 1'b1, 32);
    exp_q.push_back(8'h81);
    @(negedge clk);
    check("t4_data81", rx_data, 8'h81);
    check("t4_ferr_clr", frame_err, 0);
    check("t4_status81", rx_status, 1);

    // Reset asserted during data bit 4 of 0xFF
    align();
    send_bit(1'b0, 32);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 32);
    send_bit(1'b1, 16);
    reset = 1'b0;
    @(negedge clk);
    check("t5_data", rx_data, 0);
    check("t5_status", rx_status, 0);
    check("t5_ferr", frame_err, 0);
    check("t5_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    send_bit(1'b1, 64);
    @(negedge clk);
    check("t5_busy_rel", busy, 0);
    check("t5_status_rel", rx_status, 0);
    align();
    send_frame(8'h12, 1'b1, 32);
    exp_q.push_back(8'h12);
    @(negedge clk);
    check("t5_data12", rx_data, 8'h12);
    check("t5_status12", rx_status, 1);
    check_stream();

    // Sender running about 3% fast (31 clk per bit), then about 3% slow (33 clk per bit)
    for (int k = 0; k < 2; k++) begin
      align();
      send_bit(1'b1, 64);
      r0 = rises;
      send_frame(8'hC9, 1'b1, (k == 0) ? 31 : 33);
      exp_q.push_back(8'hC9);
      @(negedge clk);
      check($sformatf("t6_data_%0d", k), rx_data, 8'hC9);
      check($sformatf("t6_ferr_%0d", k), frame_err, 0);
      check($sformatf("t6_rise_%0d", k), rises - r0, 1);
    end
    last_good = 8'hC9;

    // Random frames. First pass: one tick every 2 clk. Second pass: tick16 held high.
    for (int pass = 0; pass < 2; pass++) begin
      tick_div = (pass == 0) ? 2 : 1;
      nb = 16 * tick_div;
      align();
      send_bit(1'b1, 2 * nb);
      for (int i = 0; i < 10; i++) begin
        d = 8'($urandom);
        stop = ($urandom_range(0, 3) != 0);
        send_frame(d, stop, nb);
        if (stop) begin
          exp_q.push_back(d);
          last_good = d;
          exp_err = 1'b0;
          exp_stat = 1'b1;
        end else begin
          exp_err = 1'b1;
          exp_stat = 1'b0;
        end
        @(negedge clk);
        check($sformatf("rnd%0d_%0d_data", pass, i), rx_data, last_good);
        check($sformatf("rnd%0d_%0d_status", pass, i), rx_status, exp_stat);
        check($sformatf("rnd%0d_%0d_ferr", pass, i), frame_err, exp_err);
        gap = stop ? $urandom_range(0, nb) : $urandom_range(nb / 2, 2 * nb);
        align();
        send_bit(1'b1, gap + 1);
      end
    end
    send_bit(1'b1, 64);
    @(negedge clk);
    check("final_busy", busy, 0);
    check_stream();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
